// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the single register-file write
// port. Grants one of NREQ write-back requesters per cycle, registers the
// winner's address/data and produces a registered one-hot word-line select.
// A write to register 0 is accepted but suppresses WEn/WSel.
// Optional build macro WB_STALL_EN adds a Stall input that freezes
// arbitration while high.
module wb_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
`ifdef WB_STALL_EN
  input  logic                 Stall,
`endif
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*AW-1:0]   Addr,
  input  logic [NREQ*DW-1:0]   Data,
  output logic [NREQ-1:0]      Gnt,
  output logic                 WEn,
  output logic [AW-1:0]        WAddr,
  output logic [DW-1:0]        WData,
  output logic [(1<<AW)-1:0]   WSel,
  output logic                 Busy
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WSW = 1 << AW;

  logic [PW-1:0]   r_ptr;
  logic            r_wen;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [WSW-1:0]  r_wsel;

  logic            w_arb_en;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic [PW-1:0]   w_idx;
  logic            w_found;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            w_wr_live;
  logic [PW-1:0]   w_ptr_nxt;

  // Arbitration is frozen during reset (and during stall when built in).
`ifdef WB_STALL_EN
  assign w_arb_en = Rst_n & ~Stall;
`else
  assign w_arb_en = Rst_n;
`endif

  // Round-robin search: first requester at or after r_ptr, wrapping.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && w_arb_en && Req[w_idx]) begin
        w_found        = 1'b1;
        w_gnt_idx      = w_idx;
        w_gnt[w_idx]   = 1'b1;
      end
    end
  end

  assign w_xfer     = w_found;
  assign w_sel_addr = Addr[w_gnt_idx*AW +: AW];
  assign w_sel_data = Data[w_gnt_idx*DW +: DW];
  // Register 0 is hard-wired: the transfer completes but never writes.
  assign w_wr_live  = w_xfer && (w_sel_addr != '0);
  assign w_ptr_nxt  = (32'(w_gnt_idx) == 32'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Pointer advance and registered write port with decoded word-line select.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wsel  <= '0;
    end else begin
      r_wen  <= w_wr_live;
      r_wsel <= w_wr_live ? ({{(WSW-1){1'b0}}, 1'b1} << w_sel_addr) : '0;
      if (w_xfer) begin
        r_ptr   <= w_ptr_nxt;
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign Gnt   = w_gnt;
  assign WEn   = r_wen;
  assign WAddr = r_waddr;
  assign WData = r_wdata;
  assign WSel  = r_wsel;
  assign Busy  = |Req;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (NREQ=4, AW=5, DW=32): directed
// scenarios with literal expectations, then randomized traffic compared
// every cycle against a behavioural round-robin model.
module tb_wb_port_arbiter;

  logic         Clk;
  logic         Rst_n;
  logic         Stall;
  logic [3:0]   Req;
  logic [19:0]  Addr;
  logic [127:0] Data;
  logic [3:0]   Gnt;
  logic         WEn;
  logic [4:0]   WAddr;
  logic [31:0]  WData;
  logic [31:0]  WSel;
  logic         Busy;

  wb_port_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
`ifdef WB_STALL_EN
    .Stall(Stall),
`endif
    .Req(Req), .Addr(Addr), .Data(Data), .Gnt(Gnt), .WEn(WEn),
    .WAddr(WAddr), .WData(WData), .WSel(WSel), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_wsel;
  logic [3:0]  last_gnt;

  // DUT values observed at the most recent check point
  logic [3:0]  obs_gnt;
  logic        obs_wen;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_wsel;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (req[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_wsel = '0;
  endtask

  // One clock: compare at negedge, advance the model at posedge, return #1 later.
  task automatic cyc();
    logic [3:0] eg;
    @(negedge Clk);
    eg = (Rst_n && !Stall) ? model_gnt(Req, m_ptr) : 4'b0000;
    obs_gnt = Gnt; obs_wen = WEn; obs_waddr = WAddr; obs_wdata = WData; obs_wsel = WSel;
    chk("gnt",   64'(Gnt),   64'(eg));
    chk("wen",   64'(WEn),   64'(m_wen));
    chk("waddr", 64'(WAddr), 64'(m_waddr));
    chk("wdata", 64'(WData), 64'(m_wdata));
    chk("wsel",  64'(WSel),  64'(m_wsel));
    chk("busy",  64'(Busy),  64'(|Req));
    @(posedge Clk);
    if (!Rst_n) begin
      model_reset();
      last_gnt = '0;
    end else if (eg != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          logic [4:0] a;
          a = Addr[i*5 +: 5];
          m_waddr = a;
          m_wdata = Data[i*32 +: 32];
          m_wen   = (a != 0);
          m_wsel  = (a != 0) ? (32'd1 << a) : 32'd0;
          m_ptr   = (i + 1) % 4;
        end
      end
      last_gnt = eg;
    end else begin
      m_wen = 1'b0; m_wsel = '0; last_gnt = '0;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic [4:0] a, input logic [31:0] d);
    Req[i] = r; Addr[i*5 +: 5] = a; Data[i*32 +: 32] = d;
  endtask

  task automatic pulse_reset();
    Rst_n = 1'b0;
    model_reset();
    cyc();
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Req = '0; Addr = '0; Data = '0;
    model_reset(); last_gnt = '0;

    // reset with all requesting, then fair rotation
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
    cyc();
    chk("rst_gnt",  64'(obs_gnt),  64'h0);
    chk("rst_wen",  64'(obs_wen),  64'h0);
    chk("rst_wsel", 64'(obs_wsel), 64'h0);
    Rst_n = 1'b1;
    cyc(); chk("rr0", 64'(obs_gnt), 64'h1);
    cyc(); chk("rr1", 64'(obs_gnt), 64'h2); chk("rr1_wsel", 64'(obs_wsel), 64'h2);
    cyc(); chk("rr2", 64'(obs_gnt), 64'h4); chk("rr2_wsel", 64'(obs_wsel), 64'h4);
    cyc(); chk("rr3", 64'(obs_gnt), 64'h8); chk("rr3_wsel", 64'(obs_wsel), 64'h8);
    cyc(); chk("rr4", 64'(obs_gnt), 64'h1); chk("rr4_wsel", 64'(obs_wsel), 64'h10);
    Req = '0;
    cyc();

    // single write from requester 2
    set_req(2, 1'b1, 5'd17, 32'hDEADBEEF);
    cyc(); chk("sw_gnt", 64'(obs_gnt), 64'h4);
    Req = '0;
    cyc();
    chk("sw_wen",   64'(obs_wen),   64'h1);
    chk("sw_waddr", 64'(obs_waddr), 64'd17);
    chk("sw_wdata", 64'(obs_wdata), 64'hDEADBEEF);
    chk("sw_wsel",  64'(obs_wsel),  64'h0002_0000);

    // register 0 write from requester 0: accepted, no write strobe
    set_req(0, 1'b1, 5'd0, 32'h12345678);
    cyc(); chk("r0_gnt", 64'(obs_gnt), 64'h1);
    Req = 4'b0011;
    cyc();
    chk("r0_wen",  64'(obs_wen),   64'h0);
    chk("r0_wsel", 64'(obs_wsel),  64'h0);
    chk("r0_ptr1", 64'(obs_gnt),   64'h2);
    Req = '0;
    cyc();

    // address 31 and pointer wrap
    set_req(3, 1'b1, 5'd31, 32'hCAFEF00D);
    cyc(); chk("a31_gnt", 64'(obs_gnt), 64'h8);
    Req = 4'b1001;
    cyc();
    chk("a31_wsel", 64'(obs_wsel), 64'h8000_0000);
    chk("wrap_gnt", 64'(obs_gnt),  64'h1);
    Req = '0;
    cyc();

    // reset mid-operation discards the registered write
    set_req(1, 1'b1, 5'd9, 32'h0BADF00D);
    cyc(); chk("mr_gnt", 64'(obs_gnt), 64'h2);
    Req = '0;
    chk("mr_wen_pre", 64'(WEn), 64'h1);
    Rst_n = 1'b0;
    #1;
    chk("mr_wen_async",  64'(WEn),  64'h0);
    chk("mr_wsel_async", 64'(WSel), 64'h0);
    model_reset();
    cyc();
    Rst_n = 1'b1;
    Req = 4'b0010;
    cyc(); chk("mr_gnt_after", 64'(obs_gnt), 64'h2);
    Req = 4'b0011;
    cyc(); chk("mr_ptr_next", 64'(obs_gnt), 64'h1);
    Req = '0;
    cyc();

`ifdef WB_STALL_EN
    pulse_reset();
    set_req(1, 1'b1, 5'd3, 32'hA1);
    set_req(2, 1'b1, 5'd4, 32'hA2);
    Stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("st_gnt", 64'(obs_gnt), 64'h0);
      chk("st_wen", 64'(obs_wen), 64'h0);
    end
    Stall = 1'b0;
    cyc(); chk("st_g1", 64'(obs_gnt), 64'h2);
    Req[1] = 1'b0;
    cyc(); chk("st_g2", 64'(obs_gnt), 64'h4); chk("st_w1", 64'(obs_wen), 64'h1);
    Req = '0;
    cyc(); chk("st_w2", 64'(obs_wen), 64'h1);
`endif

    // randomized traffic, with occasional reset and stall
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!Req[i] || last_gnt[i])
          set_req(i, ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom);
      end
`ifdef WB_STALL_EN
      Stall = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 299) == 0) begin
        Rst_n = 1'b0;
        #1;
        chk("rnd_rst_wen", 64'(WEn), 64'h0);
        model_reset();
        cyc();
        Rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between NREQ write-back requesters using round-robin arbitration.
- Each cycle it grants at most one requester and registers that requester's address and data.
- The 5-bit address feeds the 5-to-32 enabled decoder, which produces a registered one-hot word-line select for the register file.
- Sits between the execution/load units and the 32-entry register file.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 5, register address width; the decoder output is 2**AW = 32 bits.
- DW, 32, write data width.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Req  input  NREQ  per-requester write request, held until granted.
- Addr  input  NREQ*AW  packed destination addresses; requester i uses bits [i*AW +: AW].
- Data  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- Gnt  output  NREQ  combinational one-hot grant.
- WEn  output  1  registered register-file write enable.
- WAddr  output  AW  registered write address.
- WData  output  DW  registered write data.
- WSel  output  2**AW  registered one-hot decoded select; all zero when WEn=0.
- Busy  output  1  combinational; high when any Req bit is high.

Behaviour:
- Clock and reset:
  - One clock (Clk).
  - Reset is asynchronous and active-low on Rst_n.
  - While Rst_n=0:
    - Round-robin pointer ptr=0.
    - WEn=0, WAddr=0, WData=0, WSel=0.
    - Gnt forced to 0.
- Arbitration (combinational):
  - Search Req starting at index ptr, ascending, wrapping modulo NREQ.
  - The first set bit i gets Gnt[i]=1; all other Gnt bits are 0.
  - If Req=0, then Gnt=0.
- Transfer: occurs at a rising edge when Req[i]&Gnt[i]=1.
  - The requester may drop or change Req[i], Addr and Data in the following cycle.
  - Requester i must hold Addr/Data stable while Req[i]=1 and Gnt[i]=0.
- Pointer:
  - After a transfer from i, ptr <= (i+1) mod NREQ. This wraps from NREQ-1 to 0.
  - With no transfer, ptr holds.
- Latency: the write outputs are valid exactly one cycle after the transfer edge and last one cycle.
  - WAddr <= Addr[i], WData <= Data[i].
  - WEn <= 1, WSel <= 1 << Addr[i].
  - A cycle with no transfer gives WEn=0 and WSel=0; WAddr/WData hold their previous values.
- Register 0:
  - A transfer with Addr[i]=0 is accepted normally: Gnt is pulsed and ptr advances.
  - It produces WEn=0 and WSel=0, with WAddr=0 and WData captured.
- Throughput: one transfer per cycle. Back-to-back requesters are granted on consecutive cycles with no bubble.
- Fairness: with all NREQ requesting continuously, each is granted exactly once every NREQ cycles.
- Simultaneous events:
  - A newly raised Req at index ptr wins over lower-priority pending requests in the same cycle.
  - A requester that re-asserts immediately after its grant waits behind all others that are pending.
- Reset mid-operation:
  - Any pending registered write is discarded (WEn=0 immediately, asynchronously).
  - ptr returns to 0.
  - Requests still high after reset release are arbitrated from index 0.
- Out of range: AW values for which 2**AW exceeds the WSel width are not supported.

Optional Feature:
- Macro: WB_STALL_EN.
- When defined:
  - Adds input port Stall (1 bit), placed after Rst_n.
  - While Stall=1: Gnt=0, no transfer, ptr holds, and the next cycle's WEn=0 and WSel=0. Stall does not cancel a write already registered in the current cycle.
  - When Stall deasserts, arbitration resumes from the unchanged ptr.
- When not defined:
  - No Stall port.
  - Behaviour is identical to Stall tied to 0.

Test Plan:
- Reset check:
  - Stimulus: assert Rst_n=0 with Req=4'b1111.
  - Required: Gnt=0, WEn=0, WSel=0.
  - Then release reset with all requesters active.
  - Required: Gnt=0001, then 0010, 0100, 1000, 0001 on consecutive cycles; WSel follows one cycle later for each requester's address.
- Single write:
  - Stimulus: Req[2]=1 with Addr[2]=5'd17, Data[2]=32'hDEADBEEF.
  - Required: Gnt=0100 in the same cycle.
  - Next cycle: WEn=1, WAddr=17, WData=DEADBEEF, WSel=32'h0002_0000.
- Register 0 write:
  - Stimulus: Req[0]=1 with Addr[0]=0.
  - Required: Gnt[0] pulses and ptr advances to 1.
  - Next cycle: WEn=0, WSel=0.
- Address 31 and wrap:
  - Stimulus: only requester 3 requests, Addr=5'd31.
  - Required: Gnt=1000.
  - Next cycle: WSel=32'h8000_0000 and ptr=0.
  - Then Req=1001.
  - Required: requester 0 is granted first.
- Reset mid-operation:
  - Stimulus: transfer from requester 1 (Addr=9), then drop Rst_n before the next edge.
  - Required: WEn falls to 0 asynchronously.
  - After release, with Req=0010: Gnt=0010 and ptr started from 0.
- With WB_STALL_EN defined:
  - Stimulus: Req=0110, Stall=1 for 3 cycles.
  - Required: Gnt=0 and WEn=0 throughout.
  - Then Stall=0.
  - Required: Gnt=0010 then 0100, and WEn=1 on each following cycle.
